// File: rtl/ra_pkg.sv
// Shared request type and address helpers for the remote-access request router.
package ra_pkg;

   localparam int unsigned RA_MAX_ADDR_BITS = 64;
   localparam int unsigned RA_MAX_DATA_BITS = 64;

   // Request payload, sized for the widest supported configuration.
   typedef struct packed {
      logic                        read;
      logic                        write;
      logic [RA_MAX_ADDR_BITS-1:0] addr;
      logic [RA_MAX_DATA_BITS-1:0] data;
   } ra_req_t;

   // Destination core ID held in the field just above the per-core local address.
   function automatic logic [31:0] ra_dest(input logic [RA_MAX_ADDR_BITS-1:0] addr,
                                           input int unsigned                 real_bits,
                                           input int unsigned                 id_bits);
      logic [RA_MAX_ADDR_BITS-1:0] mask;
      mask = (RA_MAX_ADDR_BITS'(1) << id_bits) - RA_MAX_ADDR_BITS'(1);
      return 32'((addr >> real_bits) & mask);
   endfunction

endpackage

// File: rtl/ra_req_fifo.sv
// Request FIFO: power-of-two depth, show-ahead head, push allowed when full if popping.
module ra_req_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only read once written.
   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/ra_req_router.sv
// Routes core requests to the local cache or the network and merges their responses.
// Optional RA_PERF_CNT_EN adds saturating issue counters printed on report.
module ra_req_router
   import ra_pkg::*;
#(
   parameter int unsigned CORE           = 0,
   parameter int unsigned ID_BITS        = 4,
   parameter int unsigned REAL_ADDR_BITS = 16,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDRESS_BITS   = 32,
   parameter int unsigned BUF_DEPTH      = 4,
   parameter int unsigned MAX_OUT        = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    req_read,
   input  logic                    req_write,
   input  logic [ADDRESS_BITS-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0]   req_data,
   output logic                    req_ready,
   output logic                    resp_valid,
   output logic [ADDRESS_BITS-1:0] resp_addr,
   output logic [DATA_WIDTH-1:0]   resp_data,
   output logic                    c_read,
   output logic                    c_write,
   output logic [ADDRESS_BITS-1:0] c_addr,
   output logic [DATA_WIDTH-1:0]   c_data,
   input  logic                    c_ready,
   input  logic                    c_valid,
   input  logic [ADDRESS_BITS-1:0] c_raddr,
   input  logic [DATA_WIDTH-1:0]   c_rdata,
   output logic                    n_read,
   output logic                    n_write,
   output logic [ADDRESS_BITS-1:0] n_addr,
   output logic [DATA_WIDTH-1:0]   n_data,
   input  logic                    n_ready,
   input  logic                    n_valid,
   input  logic [ADDRESS_BITS-1:0] n_raddr,
   input  logic [DATA_WIDTH-1:0]   n_rdata,
   output logic                    n_resp_ready,
   input  logic                    report
);

   localparam int unsigned        ENTRY_W = 2 + ADDRESS_BITS + DATA_WIDTH;
   localparam int unsigned        OUT_W   = $clog2(MAX_OUT + 1);
   localparam logic [ID_BITS-1:0] CORE_ID = ID_BITS'(CORE);

   logic [ENTRY_W-1:0]      enq_entry;
   logic [ENTRY_W-1:0]      head_entry;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    accept;
   logic                    issue;
   ra_req_t                 head;
   logic                    head_local;
   logic                    target_ready;
   logic                    out_ok;
   logic [OUT_W-1:0]        outstanding;
   logic                    deliver;
   logic                    skid_full;
   logic [ADDRESS_BITS-1:0] skid_addr;
   logic [DATA_WIDTH-1:0]   skid_data;
   logic                    unused_ok;

   // Both strobes high is stored as a write.
   assign enq_entry = {req_write, req_read & ~req_write, req_addr, req_data};
   assign req_ready = ~reset & (~fifo_full | issue);
   assign accept    = (req_read | req_write) & req_ready;

   ra_req_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (accept),
      .pop   (issue),
      .wdata (enq_entry),
      .rdata (head_entry),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      head       = '0;
      head.write = head_entry[ENTRY_W-1];
      head.read  = head_entry[ENTRY_W-2];
      head.addr  = RA_MAX_ADDR_BITS'(head_entry[DATA_WIDTH +: ADDRESS_BITS]);
      head.data  = RA_MAX_DATA_BITS'(head_entry[DATA_WIDTH-1:0]);
   end

   assign head_local   = (ra_dest(head.addr, REAL_ADDR_BITS, ID_BITS) == CORE);
   assign target_ready = head_local ? c_ready : n_ready;
   assign out_ok       = (outstanding < OUT_W'(MAX_OUT));
   assign issue        = ~reset & ~fifo_empty & target_ready & (~head.read | out_ok);

   // Only the target port is driven, and only in the issuing cycle.
   always_comb begin
      c_read  = 1'b0;
      c_write = 1'b0;
      c_addr  = '0;
      c_data  = '0;
      n_read  = 1'b0;
      n_write = 1'b0;
      n_addr  = '0;
      n_data  = '0;
      if (issue) begin
         if (head_local) begin
            c_read  = head.read;
            c_write = head.write;
            c_addr  = ADDRESS_BITS'(head.addr);
            c_data  = DATA_WIDTH'(head.data);
         end else begin
            n_read  = head.read;
            n_write = head.write;
            n_addr  = ADDRESS_BITS'(head.addr);
            n_data  = DATA_WIDTH'(head.data);
         end
      end
   end

   // Response merge: skid first, then cache, then network pass-through.
   always_comb begin
      resp_valid = 1'b0;
      resp_addr  = '0;
      resp_data  = '0;
      if (!reset) begin
         if (skid_full) begin
            resp_valid = 1'b1;
            resp_addr  = skid_addr;
            resp_data  = skid_data;
         end else if (c_valid) begin
            resp_valid = 1'b1;
            resp_addr  = ADDRESS_BITS'({CORE_ID, c_raddr[REAL_ADDR_BITS-1:0]});
            resp_data  = c_rdata;
         end else if (n_valid) begin
            resp_valid = 1'b1;
            resp_addr  = n_raddr;
            resp_data  = n_rdata;
         end
      end
   end

   assign n_resp_ready = ~skid_full;
   assign deliver      = resp_valid;

   // Outstanding reads; a response with nothing outstanding leaves the count at zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         outstanding <= '0;
      end else begin
         case ({issue & head.read, deliver & (outstanding != '0)})
            2'b10:   outstanding <= outstanding + OUT_W'(1);
            2'b01:   outstanding <= outstanding - OUT_W'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         skid_full <= 1'b0;
         skid_addr <= '0;
         skid_data <= '0;
      end else if (skid_full) begin
         skid_full <= 1'b0;
      end else if (c_valid & n_valid) begin
         skid_full <= 1'b1;
         skid_addr <= n_raddr;
         skid_data <= n_rdata;
      end
   end

`ifdef RA_PERF_CNT_EN
   logic [31:0] local_cnt;
   logic [31:0] remote_cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         local_cnt  <= '0;
         remote_cnt <= '0;
      end else if (issue) begin
         if (head_local && local_cnt != '1)   local_cnt  <= local_cnt + 32'd1;
         if (!head_local && remote_cnt != '1) remote_cnt <= remote_cnt + 32'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (report) $display("ra_req_router core %0d: local issues %0d, remote issues %0d",
                           CORE, local_cnt, remote_cnt);
   end

   assign unused_ok = &{1'b0, head, c_raddr};
`else
   assign unused_ok = &{1'b0, report, head, c_raddr};
`endif

endmodule

// File: tb/tb_ra_req_router.sv
// Bench for ra_req_router: vector table, directed corner sequences, randomized run vs queue model.
module tb_ra_req_router;

   localparam int unsigned CORE    = 2;
   localparam int unsigned MAX_OUT = 2;
   localparam int unsigned DEPTH   = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_read, req_write;
   logic [31:0] req_addr, req_data;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_addr, resp_data;
   logic        c_read, c_write;
   logic [31:0] c_addr, c_data;
   logic        c_ready, c_valid;
   logic [31:0] c_raddr, c_rdata;
   logic        n_read, n_write;
   logic [31:0] n_addr, n_data;
   logic        n_ready, n_valid;
   logic [31:0] n_raddr, n_rdata;
   logic        n_resp_ready;
   logic        report;

   ra_req_router #(
      .CORE(CORE), .ID_BITS(4), .REAL_ADDR_BITS(16), .DATA_WIDTH(32),
      .ADDRESS_BITS(32), .BUF_DEPTH(DEPTH), .MAX_OUT(MAX_OUT)
   ) dut (
      .clock(clock), .reset(reset),
      .req_read(req_read), .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_addr(resp_addr), .resp_data(resp_data),
      .c_read(c_read), .c_write(c_write), .c_addr(c_addr), .c_data(c_data),
      .c_ready(c_ready), .c_valid(c_valid), .c_raddr(c_raddr), .c_rdata(c_rdata),
      .n_read(n_read), .n_write(n_write), .n_addr(n_addr), .n_data(n_data),
      .n_ready(n_ready), .n_valid(n_valid), .n_raddr(n_raddr), .n_rdata(n_rdata),
      .n_resp_ready(n_resp_ready), .report(report)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: request queue, outstanding-read count, pending network response.
   typedef struct { logic rd; logic wr; logic [31:0] addr; logic [31:0] data; } mreq_t;
   typedef struct { logic [31:0] addr; logic [31:0] data; } mresp_t;

   mreq_t  mq[$];
   mresp_t skq[$];
   int     m_out = 0;

   logic        e_req_ready, e_issue, e_local;
   logic        e_c_read, e_c_write, e_n_read, e_n_write;
   logic [31:0] e_c_addr, e_c_data, e_n_addr, e_n_data;
   logic        e_resp_valid, e_n_resp_ready;
   logic [31:0] e_resp_addr, e_resp_data;

   function automatic bit is_local(input logic [31:0] a);
      return ((a >> 16) & 32'hF) == CORE;
   endfunction

   task automatic model_eval();
      mreq_t h;
      e_req_ready = 0; e_issue = 0; e_local = 0;
      e_c_read = 0; e_c_write = 0; e_c_addr = 0; e_c_data = 0;
      e_n_read = 0; e_n_write = 0; e_n_addr = 0; e_n_data = 0;
      e_resp_valid = 0; e_resp_addr = 0; e_resp_data = 0;
      e_n_resp_ready = (skq.size() == 0);
      if (!reset) begin
         if (mq.size() > 0) begin
            h       = mq[0];
            e_local = is_local(h.addr);
            e_issue = (e_local ? c_ready : n_ready) && (h.wr || m_out < int'(MAX_OUT));
            if (e_issue && e_local) begin
               e_c_read = !h.wr; e_c_write = h.wr; e_c_addr = h.addr; e_c_data = h.data;
            end else if (e_issue) begin
               e_n_read = !h.wr; e_n_write = h.wr; e_n_addr = h.addr; e_n_data = h.data;
            end
         end
         e_req_ready = (mq.size() < int'(DEPTH)) || e_issue;
         if (skq.size() > 0) begin
            e_resp_valid = 1; e_resp_addr = skq[0].addr; e_resp_data = skq[0].data;
         end else if (c_valid) begin
            e_resp_valid = 1;
            e_resp_addr  = (32'(CORE) << 16) | (c_raddr & 32'h0000_FFFF);
            e_resp_data  = c_rdata;
         end else if (n_valid) begin
            e_resp_valid = 1; e_resp_addr = n_raddr; e_resp_data = n_rdata;
         end
      end
   endtask

   task automatic model_check();
      chk("req_ready", req_ready, e_req_ready);
      chk("c_read", c_read, e_c_read);
      chk("c_write", c_write, e_c_write);
      chk("c_addr", c_addr, e_c_addr);
      chk("c_data", c_data, e_c_data);
      chk("n_read", n_read, e_n_read);
      chk("n_write", n_write, e_n_write);
      chk("n_addr", n_addr, e_n_addr);
      chk("n_data", n_data, e_n_data);
      chk("resp_valid", resp_valid, e_resp_valid);
      chk("resp_addr", resp_addr, e_resp_addr);
      chk("resp_data", resp_data, e_resp_data);
      chk("n_resp_ready", n_resp_ready, e_n_resp_ready);
   endtask

   task automatic model_update();
      mreq_t  r;
      mresp_t s;
      int     inc, dec;
      if (reset) begin
         mq.delete(); skq.delete(); m_out = 0;
      end else begin
         inc = (e_issue && !mq[0].wr) ? 1 : 0;
         dec = (e_resp_valid && m_out > 0) ? 1 : 0;
         if (e_issue) void'(mq.pop_front());
         if ((req_read || req_write) && e_req_ready) begin
            r.rd = req_read && !req_write; r.wr = req_write; r.addr = req_addr; r.data = req_data;
            mq.push_back(r);
         end
         m_out = m_out + inc - dec;
         if (skq.size() > 0) void'(skq.pop_front());
         else if (c_valid && n_valid) begin
            s.addr = n_raddr; s.data = n_rdata;
            skq.push_back(s);
         end
      end
   endtask

   task automatic half();
      @(negedge clock);
      model_eval();
      model_check();
   endtask

   task automatic finish_cycle();
      @(posedge clock);
      model_update();
      #1;
      cyc++;
   endtask

   task automatic step();
      half();
      finish_cycle();
   endtask

   task automatic set_idle();
      reset = 0; req_read = 0; req_write = 0; req_addr = 0; req_data = 0;
      c_ready = 0; c_valid = 0; c_raddr = 0; c_rdata = 0;
      n_ready = 0; n_valid = 0; n_raddr = 0; n_rdata = 0; report = 0;
   endtask

   typedef struct {
      logic rst; logic rd; logic wr; logic [31:0] addr; logic [31:0] wdata;
      logic cr; logic nr; logic cv; logic [31:0] craddr; logic [31:0] crdata;
      logic nv; logic [31:0] nraddr; logic [31:0] nrdata;
      logic x_ready; logic x_cwr; logic [31:0] x_caddr; logic [31:0] x_cdata; logic x_nany;
      logic x_rv; logic [31:0] x_raddr; logic [31:0] x_rdata; logic x_nrr;
   } vec_t;

   vec_t vt[9];

   initial begin
      // rst rd wr addr wdata | cr nr cv craddr crdata | nv nraddr nrdata || ready cwr caddr cdata nany rv raddr rdata nrr
      vt[0] = '{1,0,1,32'h0002_0010,32'h1234, 1,0,0,32'h0,32'h0, 0,32'h0,32'h0,
                0,0,32'h0,32'h0,0, 0,32'h0,32'h0,1};
      vt[1] = '{0,0,1,32'h0002_0010,32'h1234, 1,0,0,32'h0,32'h0, 0,32'h0,32'h0,
                1,0,32'h0,32'h0,0, 0,32'h0,32'h0,1};
      vt[2] = '{0,0,0,32'h0,32'h0, 1,0,0,32'h0,32'h0, 0,32'h0,32'h0,
                1,1,32'h0002_0010,32'h1234,0, 0,32'h0,32'h0,1};
      vt[3] = '{0,1,1,32'h0002_0020,32'h99, 1,0,0,32'h0,32'h0, 0,32'h0,32'h0,
                1,0,32'h0,32'h0,0, 0,32'h0,32'h0,1};
      vt[4] = '{0,0,0,32'h0,32'h0, 1,0,1,32'hFFF3_0008,32'hAAAA, 1,32'h0005_0004,32'h5555,
                1,1,32'h0002_0020,32'h99,0, 1,32'h0002_0008,32'hAAAA,1};
      vt[5] = '{0,0,0,32'h0,32'h0, 1,0,1,32'h0000_0004,32'hBBBB, 0,32'h0,32'h0,
                1,0,32'h0,32'h0,0, 1,32'h0005_0004,32'h5555,0};
      vt[6] = '{0,0,0,32'h0,32'h0, 1,0,1,32'h0000_0004,32'hBBBB, 0,32'h0,32'h0,
                1,0,32'h0,32'h0,0, 1,32'h0002_0004,32'hBBBB,1};
      vt[7] = '{0,0,0,32'h0,32'h0, 0,0,0,32'h0,32'h0, 1,32'h0005_0000,32'h77,
                1,0,32'h0,32'h0,0, 1,32'h0005_0000,32'h77,1};
      vt[8] = '{0,0,0,32'h0,32'h0, 0,0,0,32'h0,32'h0, 0,32'h0,32'h0,
                1,0,32'h0,32'h0,0, 0,32'h0,32'h0,1};

      set_idle();
      reset = 1;
      @(posedge clock);
      #1;

      for (int i = 0; i < 9; i++) begin
         reset = vt[i].rst; req_read = vt[i].rd; req_write = vt[i].wr;
         req_addr = vt[i].addr; req_data = vt[i].wdata;
         c_ready = vt[i].cr; n_ready = vt[i].nr;
         c_valid = vt[i].cv; c_raddr = vt[i].craddr; c_rdata = vt[i].crdata;
         n_valid = vt[i].nv; n_raddr = vt[i].nraddr; n_rdata = vt[i].nrdata;
         half();
         chk("tbl_req_ready", req_ready, vt[i].x_ready);
         chk("tbl_c_write", c_write, vt[i].x_cwr);
         chk("tbl_c_addr", c_addr, vt[i].x_caddr);
         chk("tbl_c_data", c_data, vt[i].x_cdata);
         chk("tbl_n_any", n_read | n_write, vt[i].x_nany);
         chk("tbl_resp_valid", resp_valid, vt[i].x_rv);
         chk("tbl_resp_addr", resp_addr, vt[i].x_raddr);
         chk("tbl_resp_data", resp_data, vt[i].x_rdata);
         chk("tbl_n_resp_ready", n_resp_ready, vt[i].x_nrr);
         finish_cycle();
      end

      // Network stalled: four remote reads fill the FIFO, two more are refused.
      for (int i = 0; i < 6; i++) begin
         set_idle();
         req_read = 1;
         req_addr = 32'h0005_0004 + 32'(4 * i);
         req_data = 32'(i);
         half();
         chk("fill_req_ready", req_ready, 32'(i < 4));
         chk("stall_n_read", n_read, 0);
         finish_cycle();
      end
      set_idle(); n_ready = 1;
      half();
      chk("first_n_read", n_read, 1);
      chk("first_n_addr", n_addr, 32'h0005_0004);
      finish_cycle();
      half();
      chk("second_n_read", n_read, 1);
      chk("second_n_addr", n_addr, 32'h0005_0008);
      finish_cycle();
      half();
      chk("limit_n_read", n_read, 0);
      finish_cycle();
      n_valid = 1; n_raddr = 32'h0005_0004; n_rdata = 32'h11;
      half();
      chk("limit_resp_n_read", n_read, 0);
      chk("limit_resp_valid", resp_valid, 1);
      finish_cycle();
      n_valid = 0;
      half();
      chk("third_n_read", n_read, 1);
      chk("third_n_addr", n_addr, 32'h0005_000C);
      finish_cycle();
      for (int i = 0; i < 6; i++) begin
         n_valid = 1; n_rdata = 32'(100 + i);
         step();
      end

      // Reset with three queued local writes discards them.
      set_idle();
      for (int i = 0; i < 3; i++) begin
         req_write = 1; req_addr = 32'h0002_0100 + 32'(i); req_data = 32'(i);
         step();
      end
      set_idle(); reset = 1; req_write = 1; req_addr = 32'h0002_0200; c_valid = 1; c_ready = 1;
      half();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_c_write", c_write, 0);
      chk("rst_resp_valid", resp_valid, 0);
      finish_cycle();
      set_idle(); c_ready = 1; n_ready = 1;
      half();
      chk("post_rst_c_write", c_write, 0);
      chk("post_rst_n_any", n_read | n_write, 0);
      chk("post_rst_req_ready", req_ready, 1);
      finish_cycle();
      set_idle(); n_valid = 1; n_raddr = 32'h0007_0040; n_rdata = 32'hCAFE;
      half();
      chk("post_rst_resp_valid", resp_valid, 1);
      chk("post_rst_resp_data", resp_data, 32'hCAFE);
      finish_cycle();

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         reset     = ($urandom_range(0, 199) == 0);
         req_read  = ($urandom_range(0, 2) == 0);
         req_write = ($urandom_range(0, 2) == 0);
         req_addr  = $urandom;
         if ($urandom_range(0, 1) == 1) req_addr[19:16] = 4'(CORE);
         req_data  = $urandom;
         c_ready   = ($urandom_range(0, 3) != 0);
         n_ready   = ($urandom_range(0, 2) != 0);
         c_valid   = ($urandom_range(0, 3) == 0);
         n_valid   = ($urandom_range(0, 3) == 0);
         c_raddr   = $urandom;
         c_rdata   = $urandom;
         n_raddr   = $urandom;
         n_rdata   = $urandom;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
